// File: rtl/match_code_packer.sv
// Turns each input word plus its comparator result into a variable-length codeword
// and packs the codewords MSB-first into 64-bit output words over valid/ready.
module match_code_packer #(
  parameter int INPUT_WORD = 32,
  parameter int DICT_ENTRY = 16,
  parameter int OUT_WORD   = 64,
  parameter int BUF_BITS   = 128
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [INPUT_WORD-1:0]         i_word,
  input  logic [1:0]                    i_type_matched,
  input  logic                          i_align,
  input  logic [$clog2(DICT_ENTRY)-1:0] i_location,
  input  logic                          i_last,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [OUT_WORD-1:0]           o_data,
  output logic [6:0]                    o_nbits,
  output logic                          o_last
);

  localparam int LOC_W  = $clog2(DICT_ENTRY);
  localparam int CODE_W = INPUT_WORD + 2;
  localparam int LEN_W  = 6;
  localparam int FILL_W = $clog2(BUF_BITS + 1);
  localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_WORD);
  localparam logic [FILL_W-1:0] S1_LIMIT = FILL_W'(BUF_BITS - CODE_W);

  logic [CODE_W-1:0]   code_next;
  logic [LEN_W-1:0]    len_next;
  logic                s1_valid_reg;
  logic [CODE_W-1:0]   s1_code_reg;
  logic [LEN_W-1:0]    s1_len_reg;
  logic                s1_last_reg;
  logic [BUF_BITS-1:0] buf_reg, buf_next, buf_shift, append_bits;
  logic [FILL_W-1:0]   fill_reg, fill_next, fill_rem, drained;
  logic                last_pending_reg, last_pending_next;
  logic                s1_accept, s1_move, out_fire;

  // Codeword left-aligned in a CODE_W field; the zero check outranks the match type.
  always_comb begin
    code_next = '0;
    len_next  = LEN_W'(2);
    if (i_word != '0) begin
      case (i_type_matched)
        2'd3: begin
          code_next = {2'b10, i_location, {(CODE_W-2-LOC_W){1'b0}}};
          len_next  = LEN_W'(2 + LOC_W);
        end
        2'd2: begin
          code_next = {4'b1110, i_location, i_align, i_word[7:0], {(CODE_W-13-LOC_W){1'b0}}};
          len_next  = LEN_W'(13 + LOC_W);
        end
        2'd1: begin
          code_next = {4'b1100, i_location, i_align, i_word[15:0], {(CODE_W-21-LOC_W){1'b0}}};
          len_next  = LEN_W'(21 + LOC_W);
        end
        default: begin
          code_next = {2'b01, i_word};
          len_next  = LEN_W'(CODE_W);
        end
      endcase
    end
  end

  // Stage-1 code is held while the next block would mix into a pending final word.
  assign s1_move   = s1_valid_reg && !last_pending_reg && (fill_reg <= S1_LIMIT);
  assign o_ready   = !s1_valid_reg || s1_move;
  assign s1_accept = i_valid && o_ready;

  assign o_valid  = (fill_reg >= OUT_FILL) || (last_pending_reg && (fill_reg != '0));
  assign o_data   = buf_reg[BUF_BITS-1 -: OUT_WORD];
  assign o_nbits  = (fill_reg >= OUT_FILL) ? 7'(OUT_WORD) : 7'(fill_reg);
  assign o_last   = last_pending_reg && (fill_reg <= OUT_FILL);
  assign out_fire = o_valid && i_ready;

  always_comb begin
    drained     = out_fire ? ((fill_reg >= OUT_FILL) ? OUT_FILL : fill_reg) : '0;
    buf_shift   = out_fire ? (buf_reg << OUT_WORD) : buf_reg;
    fill_rem    = fill_reg - drained;
    // Bits below fill are always zero, so OR places the code right after the remainder.
    append_bits = {s1_code_reg, {(BUF_BITS-CODE_W){1'b0}}} >> fill_rem;
    buf_next    = s1_move ? (buf_shift | append_bits) : buf_shift;
    fill_next   = fill_rem + (s1_move ? FILL_W'(s1_len_reg) : '0);
    last_pending_next = (last_pending_reg && !(out_fire && o_last)) || (s1_move && s1_last_reg);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_reg     <= 1'b0;
      s1_code_reg      <= '0;
      s1_len_reg       <= '0;
      s1_last_reg      <= 1'b0;
      buf_reg          <= '0;
      fill_reg         <= '0;
      last_pending_reg <= 1'b0;
    end else begin
      if (s1_accept) begin
        s1_valid_reg <= 1'b1;
        s1_code_reg  <= code_next;
        s1_len_reg   <= len_next;
        s1_last_reg  <= i_last;
      end else if (s1_move) begin
        s1_valid_reg <= 1'b0;
      end
      buf_reg          <= buf_next;
      fill_reg         <= fill_next;
      last_pending_reg <= last_pending_next;
    end
  end

endmodule

// File: tb/tb_match_code_packer.sv
// Directed-vector bench for match_code_packer with hand-computed output words.
module tb_match_code_packer;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, o_ready, i_align, i_last, o_valid, i_ready, o_last;
  logic [31:0] i_word;
  logic [1:0]  i_type_matched;
  logic [3:0]  i_location;
  logic [63:0] o_data;
  logic [6:0]  o_nbits;

  match_code_packer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .i_type_matched(i_type_matched), .i_align(i_align),
    .i_location(i_location), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_nbits(o_nbits), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  logic [63:0] q_data[$];
  logic [6:0]  q_nbits[$];
  logic        q_last[$];

  logic        hold_reg = 1'b0;
  logic [63:0] hold_data;
  logic [6:0]  hold_nbits;
  logic        hold_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Output monitor: records transfers and checks that stalled words hold steady.
  always @(negedge i_clk) begin
    #1;
    if (!i_reset && o_valid && i_ready) begin
      q_data.push_back(o_data);
      q_nbits.push_back(o_nbits);
      q_last.push_back(o_last);
      $display("out data=%h nbits=%0d last=%0d", o_data, o_nbits, o_last);
    end
    if (!i_reset && o_valid && !i_ready) begin
      if (hold_reg) begin
        check("hold_data", o_data, hold_data);
        check("hold_nbits", 64'(o_nbits), 64'(hold_nbits));
        check("hold_last", 64'(o_last), 64'(hold_last));
      end
      hold_reg = 1'b1; hold_data = o_data; hold_nbits = o_nbits; hold_last = o_last;
    end else begin
      hold_reg = 1'b0;
    end
  end

  task automatic send(input logic [31:0] w, input logic [1:0] t, input logic a,
                      input logic [3:0] loc, input logic last);
    int n = 0;
    i_valid = 1'b1; i_word = w; i_type_matched = t; i_align = a; i_location = loc; i_last = last;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    stalls += n;
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_outputs(input string tag, input int n);
    int c = 0;
    while (q_data.size() < n && c < 300) begin
      @(negedge i_clk);
      c++;
    end
    repeat (6) @(negedge i_clk);
    check(tag, 64'(q_data.size()), 64'(n));
  endtask

  task automatic expect_word(input string tag, input int k, input logic [63:0] d,
                             input logic [6:0] nb, input logic l);
    if (k < q_data.size()) begin
      check({tag, "_data"}, q_data[k], d);
      check({tag, "_nbits"}, 64'(q_nbits[k]), 64'(nb));
      check({tag, "_last"}, 64'(q_last[k]), 64'(l));
    end else begin
      check({tag, "_missing"}, 64'(q_data.size()), 64'(k + 1));
    end
  endtask

  task automatic clear_q();
    q_data.delete(); q_nbits.delete(); q_last.delete();
  endtask

  function automatic logic [63:0] pat_word(input int j);
    logic [5:0]  pat = 6'b100101;
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = pat[5 - ((64*j + i) % 6)];
    return r;
  endfunction

  logic [31:0]  bp_words[6] = '{32'h89ABCDEF, 32'h01234567, 32'hFFFFFFFF,
                                32'h80000001, 32'h13579BDF, 32'h2468ACE0};
  logic [255:0] exp_stream, tmp;
  logic         saw_not_ready;

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_word = '0; i_type_matched = '0; i_align = 1'b0;
    i_location = '0; i_last = 1'b0; i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check("rst_o_valid", 64'(o_valid), 64'(0));
    check("rst_o_data", o_data, 64'h0);
    check("rst_o_nbits", 64'(o_nbits), 64'(0));
    check("rst_o_last", 64'(o_last), 64'(0));
    check("rst_o_ready", 64'(o_ready), 64'(1));
    @(negedge i_clk);

    // Type 0 literal.
    send(32'hDEADBEEF, 2'd0, 1'b0, 4'd0, 1'b1);
    wait_outputs("t0_count", 1);
    expect_word("t0", 0, 64'h77AB6FBBC0000000, 7'd34, 1'b1);
    clear_q();

    // Full match then zero word.
    send(32'h00000055, 2'd3, 1'b0, 4'd5, 1'b0);
    send(32'h00000000, 2'd3, 1'b0, 4'd5, 1'b1);
    wait_outputs("t3z_count", 1);
    expect_word("t3z", 0, 64'h9400000000000000, 7'd8, 1'b1);
    clear_q();

    // Upper two bytes match.
    send(32'h1234ABCD, 2'd1, 1'b1, 4'd3, 1'b1);
    wait_outputs("t1_count", 1);
    expect_word("t1", 0, 64'hC3D5E68000000000, 7'd25, 1'b1);
    clear_q();

    // Upper three bytes match: 1110 0111 0 EF -> 17 bits.
    send(32'h000000EF, 2'd2, 1'b0, 4'd7, 1'b1);
    wait_outputs("t2_count", 1);
    expect_word("t2", 0, 64'hE777800000000000, 7'd17, 1'b1);
    clear_q();

    // 32 back-to-back full matches.
    stalls = 0;
    for (int k = 0; k < 32; k++) send(32'h0000AAAA, 2'd3, 1'b0, 4'd5, k == 31);
    check("stream_no_stall", 64'(stalls), 64'(0));
    wait_outputs("stream_count", 3);
    for (int j = 0; j < 3; j++) expect_word($sformatf("stream%0d", j), j, pat_word(j), 7'd64, j == 2);
    clear_q();

    // Back-pressure with literal words.
    exp_stream = '0;
    for (int k = 0; k < 6; k++) begin
      tmp = 256'({2'b01, bp_words[k]});
      exp_stream |= tmp << (222 - 34*k);
    end
    saw_not_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(bp_words[k], 2'd0, 1'b0, 4'd0, k == 5);
      end
      begin
        i_ready = 1'b0;
        repeat (20) begin
          @(negedge i_clk);
          #1;
          if (!o_ready) saw_not_ready = 1'b1;
        end
        i_ready = 1'b1;
      end
    join
    check("bp_ready_drop", 64'(saw_not_ready), 64'(1));
    wait_outputs("bp_count", 4);
    for (int j = 0; j < 4; j++)
      expect_word($sformatf("bp%0d", j), j, exp_stream[255 - 64*j -: 64],
                  (j == 3) ? 7'd12 : 7'd64, j == 3);
    clear_q();

    // Reset with 40 bits buffered, then a fresh block.
    send(32'h55AA55AA, 2'd0, 1'b0, 4'd0, 1'b0);
    send(32'h00001111, 2'd3, 1'b0, 4'd5, 1'b0);
    repeat (3) @(negedge i_clk);
    #1;
    check("pre_rst_o_valid", 64'(o_valid), 64'(0));
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check("mid_rst_o_valid", 64'(o_valid), 64'(0));
    check("mid_rst_o_ready", 64'(o_ready), 64'(1));
    @(negedge i_clk);
    send(32'h00002222, 2'd3, 1'b0, 4'd10, 1'b1);
    wait_outputs("post_rst_count", 1);
    expect_word("post_rst", 0, 64'hA800000000000000, 7'd6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
